// File: rtl/uart_pkg.sv
// Shared UART receive definitions: baud-select codes, receiver states, divisor helper.
// UART_RX_PARITY_EN adds the PARITY state (8E1 framing).
package uart_pkg;

  typedef enum logic [1:0] {
    BR_9600   = 2'b00,
    BR_19200  = 2'b01,
    BR_57600  = 2'b10,
    BR_115200 = 2'b11
  } baud_sel_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_RECOVER
  } rx_state_e;

  // Rounded 16x-oversample divisor.
  function automatic int unsigned calc_div(int unsigned clk_hz, int unsigned baud);
    return (clk_hz + 8 * baud) / (16 * baud);
  endfunction

endpackage

// File: rtl/uart_byte_rx_if.sv
// Received-byte delivery bus: byte plus one-cycle valid / framing-error strobes.
interface uart_byte_rx_if;
  logic [7:0] byte_data;
  logic       data_valid;
  logic       frame_err;

  modport master (output byte_data, data_valid, frame_err);
  modport slave  (input  byte_data, data_valid, frame_err);
endinterface

// File: rtl/uart_byte_rx_baud_tick_gen.sv
// 16x oversample tick generator; rate chosen by the latched select, restarted by clr.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [1:0] rate_sel,
  output logic       tick
);
  localparam int unsigned CW = $clog2(calc_div(CLK_HZ, 9600));

  logic [CW-1:0] cnt_q, cnt_d, lim;

  always_comb begin
    lim = '0;
    case (baud_sel_e'(rate_sel))
      BR_9600:   lim = CW'(calc_div(CLK_HZ, 9600)   - 1);
      BR_19200:  lim = CW'(calc_div(CLK_HZ, 19200)  - 1);
      BR_57600:  lim = CW'(calc_div(CLK_HZ, 57600)  - 1);
      default:   lim = CW'(calc_div(CLK_HZ, 115200) - 1);
    endcase
  end

  assign tick  = !clr && (cnt_q == lim);
  assign cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_byte_rx.sv
// UART byte receiver: 2-flop sync, 16x oversampled 8N1 frame recovery, byte/error strobes.
// Define UART_RX_PARITY_EN for 8E1 framing with even-parity checking.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx_input,
  input  logic [1:0]     brate_selection,
  uart_byte_rx_if.master rx_if
);
  rx_state_e  state_q, state_d;
  logic [1:0] sync_q, sync_d;
  logic [1:0] rate_q, rate_d;
  logic [3:0] samp_q, samp_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] byte_q, byte_d;
  logic       dv_q, dv_d;
  logic       fe_q, fe_d;
  logic       rx_s, tick, clr, mid_tick, bit_tick, par_ok;

  assign rx_s     = sync_q[1];
  assign sync_d   = {sync_q[0], rx_input};
  assign mid_tick = tick && (samp_q == 4'd7);
  assign bit_tick = tick && (samp_q == 4'd15);

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  assign par_ok = ((^shift_q) == par_q);
`else
  assign par_ok = 1'b1;
`endif

  baud_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .rate_sel (rate_q),
    .tick     (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (!rx_s) state_d = S_START;
      S_START:   if (mid_tick) state_d = rx_s ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
      S_DATA:    if (bit_tick && bit_q == 3'd7) state_d = S_PARITY;
      S_PARITY:  if (bit_tick) state_d = S_STOP;
`else
      S_DATA:    if (bit_tick && bit_q == 3'd7) state_d = S_STOP;
`endif
      // Leaving STOP at mid-bit lets a back-to-back start edge be caught.
      S_STOP:    if (bit_tick) state_d = (rx_s && par_ok) ? S_IDLE : S_RECOVER;
      S_RECOVER: if (rx_s) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    clr     = 1'b0;
    rate_d  = rate_q;
    samp_d  = samp_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        clr    = 1'b1;
        samp_d = '0;
        bit_d  = '0;
        if (!rx_s) rate_d = brate_selection;
      end
      S_START: if (tick) samp_d = mid_tick ? 4'd0 : samp_q + 4'd1;
      S_DATA: begin
        if (tick) samp_d = samp_q + 4'd1;
        if (bit_tick) begin
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) samp_d = samp_q + 4'd1;
        if (bit_tick) par_d = rx_s;
      end
`endif
      S_STOP: begin
        if (tick) samp_d = samp_q + 4'd1;
        if (bit_tick) begin
          if (rx_s && par_ok) begin
            byte_d = shift_q;
            dv_d   = 1'b1;
          end else begin
            fe_d   = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b11;
      rate_q  <= brate_selection;
      samp_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      sync_q  <= sync_d;
      rate_q  <= rate_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign rx_if.byte_data  = byte_q;
  assign rx_if.data_valid = dv_q;
  assign rx_if.frame_err  = fe_q;
endmodule

// File: tb/tb_uart_byte_rx.sv
// Scoreboard bench for uart_byte_rx: a serial driver predicts each strobe, a monitor checks it.
module tb_uart_byte_rx;
  localparam int unsigned CLK_HZ = 10_000_000;
`ifdef UART_RX_PARITY_EN
  localparam int NSAMP = 10;
`else
  localparam int NSAMP = 9;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_input;
  logic [1:0] brate_selection;

  uart_byte_rx_if bus ();

  uart_byte_rx #(.CLK_HZ(CLK_HZ)) dut (
    .clk             (clk),
    .rst             (rst),
    .rx_input        (rx_input),
    .brate_selection (brate_selection),
    .rx_if           (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         t;
  } exp_t;

  exp_t       sb[$];
  exp_t       e_mon;
  int         checks = 0, errors = 0, npulse = 0;
  logic [7:0] last_good = 8'h00;

  function automatic int div_of(logic [1:0] sel);
    int b;
    case (sel)
      2'd0:    b = 9600;
      2'd1:    b = 19200;
      2'd2:    b = 57600;
      default: b = 115200;
    endcase
    return (int'(CLK_HZ) + 8 * b) / (16 * b);
  endfunction

  task automatic wait_clks(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame with exact bit timing and predicts the resulting strobe.
  task automatic send(logic [7:0] d, logic [1:0] sel, bit stop_bit, bit bad_par, bit toggle);
    int   dv = div_of(sel);
    int   bt = 16 * dv;
    exp_t e;
    bit   err;
`ifdef UART_RX_PARITY_EN
    err = !stop_bit || bad_par;
`else
    err = !stop_bit;
`endif
    brate_selection = sel;
    e.err  = err;
    e.data = err ? last_good : d;
    e.t    = cyc + 3 + 8 * dv + NSAMP * bt;
    sb.push_back(e);
    if (!err) last_good = d;
    rx_input = 1'b0;
    wait_clks(bt);
    for (int i = 0; i < 8; i++) begin
      rx_input = d[i];
      if (toggle && i == 2) brate_selection = 2'd3;
      if (toggle && i == 6) brate_selection = sel;
      wait_clks(bt);
    end
`ifdef UART_RX_PARITY_EN
    rx_input = (^d) ^ bad_par;
    wait_clks(bt);
`endif
    rx_input = stop_bit;
    wait_clks(bt);
    rx_input = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && (bus.data_valid || bus.frame_err)) begin
        npulse++;
        checks++;
        if (bus.data_valid && bus.frame_err) begin
          errors++;
          $display("FAIL both_strobes at cycle %0d: data_valid and frame_err both 1, required at most one", cyc);
        end
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse at cycle %0d: dv=%0b fe=%0b, required no pulse",
                   cyc, bus.data_valid, bus.frame_err);
        end else begin
          e_mon = sb.pop_front();
          checks++;
          if (bus.frame_err != e_mon.err) begin
            errors++;
            $display("FAIL pulse_kind at cycle %0d: frame_err=%0b, required %0b", cyc, bus.frame_err, e_mon.err);
          end
          checks++;
          if (bus.byte_data !== e_mon.data) begin
            errors++;
            $display("FAIL byte_data at cycle %0d: got %02h, required %02h", cyc, bus.byte_data, e_mon.data);
          end
          checks++;
          if (cyc < e_mon.t - 1 || cyc > e_mon.t + 1) begin
            errors++;
            $display("FAIL pulse_time: got cycle %0d, required %0d +-1", cyc, e_mon.t);
          end
        end
      end
    end
  end

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d81;
    int         bt;
    rst = 1'b1;
    rx_input = 1'b1;
    brate_selection = 2'd0;
    wait_clks(5);
    checks++;
    if (bus.byte_data !== 8'h00) begin errors++; $display("FAIL reset_byte: got %02h, required 00", bus.byte_data); end
    checks++;
    if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %0b, required 0", bus.data_valid); end
    checks++;
    if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_fe: got %0b, required 0", bus.frame_err); end
    rst = 1'b0;

    wait_clks(20000);
    checks++;
    if (npulse != 0) begin errors++; $display("FAIL idle_quiet: got %0d pulses, required 0", npulse); end

    send(8'hA5, 2'd3, 1'b1, 1'b0, 1'b0);
    wait_clks(2 * 16 * div_of(2'd3));

    // Glitch well short of half a bit, then a real frame.
    brate_selection = 2'd3;
    rx_input = 1'b0;
    wait_clks(4 * div_of(2'd3));
    rx_input = 1'b1;
    wait_clks(2 * 16 * div_of(2'd3));
    send(8'h3C, 2'd3, 1'b1, 1'b0, 1'b0);
    wait_clks(2 * 16 * div_of(2'd3));

    send(8'h55, 2'd2, 1'b0, 1'b0, 1'b0);
    wait_clks(2 * 16 * div_of(2'd2));
    send(8'h0F, 2'd2, 1'b1, 1'b0, 1'b0);
    wait_clks(2 * 16 * div_of(2'd2));

    // Back-to-back at 9600 with the select wiggled during the first frame.
    send(8'h00, 2'd0, 1'b1, 1'b0, 1'b1);
    send(8'hFF, 2'd0, 1'b1, 1'b0, 1'b0);
    wait_clks(2 * 16 * div_of(2'd0));

    // Abort 0x81 with reset in the middle of bit 4.
    d81 = 8'h81;
    bt = 16 * div_of(2'd3);
    brate_selection = 2'd3;
    rx_input = 1'b0;
    wait_clks(bt);
    for (int i = 0; i < 4; i++) begin
      rx_input = d81[i];
      wait_clks(bt);
    end
    rx_input = d81[4];
    wait_clks(bt / 2);
    rst = 1'b1;
    rx_input = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    last_good = 8'h00;
    checks++;
    if (bus.byte_data !== 8'h00) begin errors++; $display("FAIL midframe_reset_byte: got %02h, required 00", bus.byte_data); end
    wait_clks(2 * bt);
    send(8'h7E, 2'd3, 1'b1, 1'b0, 1'b0);
    wait_clks(2 * bt);

`ifdef UART_RX_PARITY_EN
    send(8'h01, 2'd3, 1'b1, 1'b1, 1'b0);
    wait_clks(2 * bt);
`endif

    for (int n = 0; n < 8; n++) begin
      logic [1:0] sel;
      sel = 2'($urandom_range(2, 3));
      send(8'($urandom), sel, ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) == 0), 1'b0);
      wait_clks(16 * div_of(sel) * $urandom_range(1, 3));
    end

    wait_clks(100);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses: %0d expected strobes never seen, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_byte_rx.md
# uart_byte_rx

Serial receive front end of the image-upload path: oversamples the UART line, recovers 8N1 frames (optionally 8E1) at one of four selectable baud rates, and delivers each byte with a one-cycle `data_valid` strobe. It sits directly upstream of the pixel-packing/SRAM-write logic, which consumes `byte_data`/`data_valid`. It runs entirely on the 100 MHz system clock and contains its own baud-tick generator.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency used to derive oversample divisors.
- `clk`  input  1  system clock.
- `rst`  input  1  reset; one clock, reset is synchronous and active-high.
- `rx_input`  input  1  asynchronous UART line, idle high.
- `brate_selection`  input  2  00=9600, 01=19200, 10=57600, 11=115200 baud.
- `byte_data`  output  8  last good byte, LSB received first; stable until next `data_valid`.
- `data_valid`  output  1  one-`clk` pulse when `byte_data` updates.
- `frame_err`  output  1  one-`clk` pulse on bad stop bit (or parity error when enabled).

## Operation
- `rx_input` passes through a 2-flop synchronizer (`rx_s`); the synchronizer resets to 1.
- Oversample tick: 16x baud. DIV = (CLK_HZ + 8*baud) / (16*baud), i.e. 651, 326, 109, 54 at 100 MHz. Tick counter counts 0..DIV-1 and pulses `tick` at DIV-1.
- `brate_selection` is latched on IDLE->START; changes mid-frame are ignored until the next frame.
- States:
  - IDLE: `rx_s`==0 -> START; clear tick counter and sample counter (4-bit).
  - START: on the 8th tick (mid start bit), if `rx_s`==1 -> IDLE (glitch, no output); else clear sample counter -> DATA.
  - DATA: every 16th tick, shift `rx_s` into bit 7 of the shift register (LSB first). After bit 7 -> PARITY if enabled, else STOP.
  - PARITY: sample at 16th tick -> STOP.
  - STOP: sample at 16th tick. If 1 and parity ok: `byte_data`<=shift, `data_valid`=1 -> IDLE. Otherwise `frame_err`=1, `byte_data` unchanged -> RECOVER.
  - RECOVER: wait for `rx_s`==1 (line break tolerated) -> IDLE.
- `data_valid` and `frame_err` are never high in the same cycle.
- Reset values: `byte_data`=0, `data_valid`=0, `frame_err`=0, state IDLE, latched rate=`brate_selection`, counters 0.
- Reset mid-frame: the partial byte is discarded with no pulse. Reception resumes with the next falling edge seen after reset deasserts; if the line is already low, that counts as a start and glitch rejection applies.

## Timing
- One bit = 16*DIV clocks (115200: 864; 9600: 10416).
- Mid-start check occurs 8*DIV clocks after `rx_s` falls; each later sample is 16*DIV after the previous one.
- `data_valid` rises one cycle after the mid-stop sample. With `rx_input` falling at cycle t0: t0 + 3 + 8*DIV + 9*16*DIV, ±1 cycle. At 115200 this is t0+8211.
- Back-to-back frames are accepted: IDLE is re-entered mid-stop, so a start edge half a bit later is detected.
- Latency of `frame_err` is identical to `data_valid`.

## Configuration
- `UART_RX_PARITY_EN` defined: frame is 8E1. PARITY state present; a mismatch with even parity over the 8 data bits yields `frame_err` and no `data_valid`. Latency grows by 16*DIV.
- Undefined: frame is 8N1. PARITY state and parity logic are absent.

## Structure
- Shared package `uart_pkg`: baud-select encodings, state enum, and a function computing DIV from CLK_HZ and baud.
- One sub-module: `baud_tick_gen` (rate latch input, sync clear, `tick` output).
- Synchronizer, FSM, shift register and output registers stay in `uart_byte_rx`.

## Test plan
- Reset: hold `rst` 5 cycles with `rx_input`=1 -> all outputs 0; no pulses for 20000 cycles of idle.
- Single byte 0xA5 at 115200 (8N1) -> `byte_data`=0xA5, `data_valid` high exactly one cycle at t0+8211±1, `frame_err` stays 0.
- Glitch: `rx_input` low for 200 clocks at 115200 -> no `data_valid`, no `frame_err`. A following 0x3C is received correctly.
- Framing error: send 0x55 at 57600 with stop bit 0, then line high -> one `frame_err` pulse, `byte_data` keeps its prior value. The next 0x0F is received correctly.
- Back-to-back 0x00,0xFF at 9600 with no idle gap, and `brate_selection` toggled to 11 mid-first-frame -> both bytes correct at 9600, two `data_valid` pulses 10 bit times apart.
- Reset mid-frame at bit 4 of 0x81, then send 0x7E -> no pulse for the aborted byte, 0x7E received. With `UART_RX_PARITY_EN`, sending 0x01 with parity bit 0 -> `frame_err`, no `data_valid`.
